sdq_fifo_ctrl: RTL and testbench

- FIFO controller that sequences one 1R1W store-data-queue SRAM macro (17 x 64, synchronous read, 1-cycle read latency) as an in-order queue.
- Owns the write/read pointers with wrap at DEPTH-1 and the occupancy count.
- Prefetches reads into a 2-entry output buffer so ready/valid dequeue sustains 1 entry per cycle.
- Sits between the store-data producer and consumer; the SRAM macro is instantiated outside and wired to the R0_*/W0_* ports.

---
 rtl/sdq_pkg.sv | 14 +
 rtl/sdq_out_buf.sv | 49 ++++
 rtl/sdq_fifo_ctrl.sv | 89 ++++++++
 tb/tb_sdq_fifo_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdq_pkg.sv
// Shared constants, types and pointer helper for the store-data queue controller.
package sdq_pkg;
  localparam int SDQ_DEPTH  = 17;
  localparam int SDQ_WIDTH  = 64;
  localparam int SDQ_ADDR_W = 5;

  typedef logic [SDQ_WIDTH-1:0]  sdq_data_t;
  typedef logic [SDQ_ADDR_W-1:0] sdq_addr_t;

  // Circular increment; depth need not be a power of two.
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/sdq_out_buf.sv
// 2-entry in-order output buffer with registered head; push visible at head next cycle.
// Push and pop may coincide at any fill; the caller never pushes into a full buffer without popping.
module sdq_out_buf
  import sdq_pkg::*;
#(
  parameter int WIDTH = SDQ_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       out_cnt,
  output logic [WIDTH-1:0] head_data
);
  logic [WIDTH-1:0] tail_data;
  logic             pop_ok;

  assign pop_ok = pop && (out_cnt != 2'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_cnt   <= 2'd0;
      head_data <= '0;
      tail_data <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (out_cnt == 2'd0) head_data <= push_data;
          else                 tail_data <= push_data;
          out_cnt <= out_cnt + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          out_cnt   <= out_cnt - 2'd1;
        end
        2'b11: begin
          if (out_cnt == 2'd1) begin
            head_data <= push_data;
          end else begin
            head_data <= tail_data;
            tail_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/sdq_fifo_ctrl.sv
// In-order queue over an external 1R1W SRAM with 2-entry prefetch; enq->deq_valid 3 cycles (1 with SDQ_FIFO_CTRL_BYPASS_EN).
// enq_ready drops only when the SRAM is full; a stalled consumer holds the head and throttles read issue.
module sdq_fifo_ctrl
  import sdq_pkg::*;
#(
  parameter int DEPTH  = SDQ_DEPTH,
  parameter int WIDTH  = SDQ_WIDTH,
  parameter int ADDR_W = SDQ_ADDR_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [WIDTH-1:0]             enq_data,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [WIDTH-1:0]             deq_data,
  output logic [$clog2(DEPTH+3)-1:0]   count,
  output logic [ADDR_W-1:0]            R0_addr,
  output logic                         R0_en,
  input  logic [WIDTH-1:0]             R0_data,
  output logic [ADDR_W-1:0]            W0_addr,
  output logic                         W0_en,
  output logic [WIDTH-1:0]             W0_data
);
  localparam int CNT_W = $clog2(DEPTH + 3);
  localparam int SC_W  = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [SC_W-1:0]   sram_cnt;
  logic              inflight;
  logic [1:0]        out_cnt;
  logic              enq_fire, deq_fire, wr_sram, rd_issue, buf_push, bypass;
  logic [WIDTH-1:0]  buf_data;
  logic [2:0]        pend;

  assign enq_ready = (sram_cnt < SC_W'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready && !reset;
  assign deq_valid = (out_cnt != 2'd0);
  assign deq_fire  = deq_valid && deq_ready;

  // Buffer occupancy once the pending return lands; issue only if a slot is guaranteed.
  assign pend     = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, deq_fire};
  assign rd_issue = (sram_cnt != '0) && (pend < 3'd2);

`ifdef SDQ_FIFO_CTRL_BYPASS_EN
  assign bypass   = enq_fire && (sram_cnt == '0) && !inflight &&
                    (({1'b0, out_cnt} - {2'b00, deq_fire}) < 3'd2);
  assign buf_push = inflight || bypass;
  assign buf_data = inflight ? R0_data : enq_data;
`else
  assign bypass   = 1'b0;
  assign buf_push = inflight;
  assign buf_data = R0_data;
`endif

  assign wr_sram = enq_fire && !bypass;
  assign W0_en   = wr_sram;
  assign W0_addr = wptr;
  assign W0_data = wr_sram ? enq_data : '0;
  assign R0_en   = rd_issue;
  assign R0_addr = rptr;
  assign count   = CNT_W'(sram_cnt) + CNT_W'(inflight) + CNT_W'(out_cnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr_sram)  wptr <= ADDR_W'(ptr_wrap_inc(32'(wptr), DEPTH));
      if (rd_issue) rptr <= ADDR_W'(ptr_wrap_inc(32'(rptr), DEPTH));
      if (wr_sram && !rd_issue)      sram_cnt <= sram_cnt + SC_W'(1);
      else if (!wr_sram && rd_issue) sram_cnt <= sram_cnt - SC_W'(1);
      inflight <= rd_issue;
    end
  end

  sdq_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (buf_push),
    .push_data (buf_data),
    .pop       (deq_fire),
    .out_cnt   (out_cnt),
    .head_data (deq_data)
  );
endmodule

// File: tb/tb_sdq_fifo_ctrl.sv
// Directed bench for sdq_fifo_ctrl with a behavioural 1-cycle-read SRAM.
module tb_sdq_fifo_ctrl;
  import sdq_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             enq_valid, enq_ready, deq_valid, deq_ready;
  sdq_data_t        enq_data, deq_data, R0_data, W0_data;
  logic [4:0]       count;
  sdq_addr_t        R0_addr, W0_addr;
  logic             R0_en, W0_en;
  sdq_data_t        mem [SDQ_DEPTH];

  int checks = 0;
  int failures = 0;
  int sent, got, occ;
  logic efire, dfire;

  sdq_fifo_ctrl dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .count(count),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) R0_data <= mem[R0_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pops n entries expected as base, base+1, ... within a cycle budget.
  task automatic drain(input string tag, input logic [63:0] base, input int n);
    int k;
    k = 0;
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int c = 0; c < n * 4 + 10 && k < n; c++) begin
      #1;
      if (deq_valid) begin
        chk(tag, deq_data, base + 64'(k));
        k++;
      end
      tick();
    end
    deq_ready = 1'b0;
    chk({tag, "_cnt"}, 64'(k), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0;
    #2;
    chk("rst_count", 64'(count), 0);
    chk("rst_deq_valid", 64'(deq_valid), 0);
    chk("rst_enq_ready", 64'(enq_ready), 1);
    chk("rst_r0_en", 64'(R0_en), 0);
    chk("rst_w0_en", 64'(W0_en), 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single entry into an empty queue
    enq_valid = 1'b1; enq_data = 64'hDEADBEEF_00000001;
    #1;
`ifndef SDQ_FIFO_CTRL_BYPASS_EN
    chk("single_w0_en", 64'(W0_en), 1);
    chk("single_w0_addr", 64'(W0_addr), 0);
    chk("single_w0_data", W0_data, 64'hDEADBEEF_00000001);
    tick(); enq_valid = 1'b0; #1;
    chk("single_r0_en", 64'(R0_en), 1);
    chk("single_r0_addr", 64'(R0_addr), 0);
    chk("single_dv_t1", 64'(deq_valid), 0);
    tick(); #1;
    chk("single_dv_t2", 64'(deq_valid), 0);
    chk("single_count_t2", 64'(count), 1);
    tick(); #1;
    chk("single_dv_t3", 64'(deq_valid), 1);
    chk("single_data_t3", deq_data, 64'hDEADBEEF_00000001);
`else
    chk("single_w0_en_byp", 64'(W0_en), 0);
    tick(); enq_valid = 1'b0; #1;
    chk("single_dv_t1", 64'(deq_valid), 1);
    chk("single_data_t1", deq_data, 64'hDEADBEEF_00000001);
`endif
    drain("single_pop", 64'hDEADBEEF_00000001, 1);
    #1;
    chk("single_count_end", 64'(count), 0);

    // Fill to DEPTH+2 with the consumer stalled
    deq_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      enq_valid = 1'b1; enq_data = 64'h1000 + 64'(i);
      #1;
      chk("fill_enq_ready", 64'(enq_ready), 1);
      tick();
    end
    enq_valid = 1'b0;
    tick(); tick(); tick(); #1;
    chk("full_count", 64'(count), 19);
    chk("full_enq_ready", 64'(enq_ready), 0);
    chk("full_head", deq_data, 64'h1000);
    enq_valid = 1'b1; enq_data = 64'h1013;
    #1;
    chk("full_stall_w0", 64'(W0_en), 0);
    tick();
    deq_ready = 1'b1;
    #1;
    chk("full_pop_no_free", 64'(enq_ready), 0);
    chk("full_pop_issue", 64'(R0_en), 1);
    tick();
    deq_ready = 1'b0;
    #1;
    chk("full_freed", 64'(enq_ready), 1);
    chk("full_20th_w0", 64'(W0_en), 1);
    tick();
    drain("fill_order", 64'h1001, 19);
    #1;
    chk("fill_count_end", 64'(count), 0);

    // Reset with 5 entries held
    deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq_valid = 1'b1; enq_data = 64'h2000 + 64'(i);
      tick();
    end
    enq_valid = 1'b0;
    tick(); #1;
    chk("pre_rst_count", 64'(count), 5);
    reset = 1'b1;
    #1;
    chk("mid_rst_count", 64'(count), 0);
    chk("mid_rst_deq_valid", 64'(deq_valid), 0);
    chk("mid_rst_enq_ready", 64'(enq_ready), 1);
    tick();
    reset = 1'b0;
    tick();

    // 40-value stream across the pointer wrap
    sent = 0; got = 0;
    for (int c = 0; c < 200 && got < 40; c++) begin
      enq_valid = (sent < 40); enq_data = 64'h3000 + 64'(sent); deq_ready = 1'b1;
      #1;
      if (enq_valid && enq_ready) begin
`ifndef SDQ_FIFO_CTRL_BYPASS_EN
        chk("wrap_w0_addr", 64'(W0_addr), 64'(sent % 17));
`endif
        sent++;
      end
      if (got > 0 && got < 40) chk("wrap_tput", 64'(deq_valid), 1);
      if (deq_valid) begin
        chk("wrap_data", deq_data, 64'h3000 + 64'(got));
        got++;
      end
      tick();
    end
    chk("wrap_total", 64'(got), 40);

    // Toggling consumer back-pressure
    sent = 0; got = 0; occ = 0;
    for (int c = 0; c < 200 && got < 10; c++) begin
      enq_valid = (sent < 10); enq_data = 64'h4000 + 64'(sent); deq_ready = (c % 2 == 0);
      #1;
      efire = enq_valid && enq_ready;
      dfire = deq_valid && deq_ready;
      occ = occ + int'(R0_en) + int'(efire && !W0_en) - int'(dfire);
      chk("bp_buf_bound", 64'(occ <= 2), 1);
      if (dfire) begin
        chk("bp_data", deq_data, 64'h4000 + 64'(got));
        got++;
      end
      if (efire) sent++;
      tick();
    end
    enq_valid = 1'b0; deq_ready = 1'b0;
    chk("bp_total", 64'(got), 10);
    #1;
    chk("bp_count_end", 64'(count), 0);

`ifdef SDQ_FIFO_CTRL_BYPASS_EN
    // Back-to-back bypass into an empty queue
    enq_valid = 1'b1; enq_data = 64'h5;
    #1;
    chk("byp_w0_en_a", 64'(W0_en), 0);
    tick();
    enq_data = 64'h6;
    #1;
    chk("byp_dv", 64'(deq_valid), 1);
    chk("byp_data", deq_data, 64'h5);
    chk("byp_w0_en_b", 64'(W0_en), 0);
    tick();
    enq_valid = 1'b0;
    #1;
    chk("byp_count", 64'(count), 2);
    drain("byp_order", 64'h5, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
